// File: rtl/wb_pkg.sv
// Shared types and constants for the Wishbone command master slice.
package wb_pkg;

   localparam int WB_AW = 8;
   localparam int WB_DW = 8;
   localparam int TMO_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_WAIT = 2'd2,
      ST_RSP  = 2'd3
   } wb_state_e;

   function automatic logic [TMO_W-1:0] sat_inc(input logic [TMO_W-1:0] v);
      return (v == {TMO_W{1'b1}}) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Saturating bus-cycle counter; expire_o flags the cycle on which the count
// including the current cycle reaches LIMIT.
module wb_timeout_ctr
   import wb_pkg::*;
#(
   parameter int LIMIT = 15
) (
   input  logic i_clk,
   input  logic i_reset_n,
   input  logic clear_i,
   input  logic en_i,
   output logic expire_o
);

   localparam logic [TMO_W-1:0] LIMIT_C = TMO_W'(LIMIT);

   logic [TMO_W-1:0] cnt_q;
   logic [TMO_W-1:0] cnt_d;
   logic [TMO_W-1:0] cnt_inc;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      cnt_inc = sat_inc(cnt_q);
      cnt_d   = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_inc;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expire_o = en_i && (cnt_inc >= LIMIT_C);

endmodule

// File: rtl/wb_cmd_master.sv
// Single-transfer Wishbone B4 pipelined initiator behind valid/ready cmd/rsp ports.
// Bus timeout abort is built only when WB_CMD_MASTER_TIMEOUT_EN is defined.
module wb_cmd_master
   import wb_pkg::*;
#(
   parameter int AW      = WB_AW,
   parameter int DW      = WB_DW,
   parameter int TIMEOUT = 15
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_cmd_valid,
   output logic          o_cmd_ready,
   input  logic          i_cmd_we,
   input  logic [AW-1:0] i_cmd_addr,
   input  logic [DW-1:0] i_cmd_data,
   output logic          o_rsp_valid,
   input  logic          i_rsp_ready,
   output logic [DW-1:0] o_rsp_data,
   output logic          o_rsp_err,
   output logic          o_wb_cyc,
   output logic          o_wb_stb,
   output logic          o_wb_we,
   output logic [AW-1:0] o_wb_addr,
   output logic [DW-1:0] o_wb_data,
   input  logic          i_wb_stall,
   input  logic          i_wb_ack,
   input  logic          i_wb_err,
   input  logic [DW-1:0] i_wb_data
);

   if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
      $error("wb_cmd_master: TIMEOUT must be in 1..255");
   end

   wb_state_e     state_q;
   logic          cmd_ready_q;
   logic          cyc_q;
   logic          stb_q;
   logic          we_q;
   logic [AW-1:0] addr_q;
   logic [DW-1:0] wdata_q;
   logic          rsp_valid_q;
   logic [DW-1:0] rsp_data_q;
   logic          rsp_err_q;

   logic          accept_w;
   logic          bus_done_w;
   logic          timeout_w;
   logic          end_w;
   logic          rsp_err_d;
   logic [DW-1:0] rsp_data_d;

   assign accept_w = (state_q == ST_IDLE) && i_cmd_valid;

`ifdef WB_CMD_MASTER_TIMEOUT_EN
   wb_timeout_ctr #(.LIMIT(TIMEOUT)) u_timeout (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .clear_i   (accept_w),
      .en_i      (cyc_q),
      .expire_o  (timeout_w)
   );
`else
   assign timeout_w = 1'b0;
`endif

   // A response counts only once the slave has taken the request: in REQ that
   // means STALL low on the same cycle (zero-latency slave).
   always_comb begin
      bus_done_w = cyc_q && (i_wb_ack || i_wb_err) &&
                   ((state_q == ST_WAIT) || !i_wb_stall);
      end_w      = bus_done_w || timeout_w;
      rsp_err_d  = bus_done_w ? i_wb_err : 1'b1;
      rsp_data_d = (bus_done_w && !i_wb_err && !we_q) ? i_wb_data : '0;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state_q     <= ST_IDLE;
         cmd_ready_q <= 1'b1;
         cyc_q       <= 1'b0;
         stb_q       <= 1'b0;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               if (accept_w) begin
                  we_q        <= i_cmd_we;
                  addr_q      <= i_cmd_addr;
                  wdata_q     <= i_cmd_data;
                  cyc_q       <= 1'b1;
                  stb_q       <= 1'b1;
                  cmd_ready_q <= 1'b0;
                  state_q     <= ST_REQ;
               end
            end
            ST_REQ, ST_WAIT: begin
               if (end_w) begin
                  cyc_q       <= 1'b0;
                  stb_q       <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= rsp_err_d;
                  rsp_data_q  <= rsp_data_d;
                  state_q     <= ST_RSP;
               end else if (state_q == ST_REQ && !i_wb_stall) begin
                  stb_q   <= 1'b0;
                  state_q <= ST_WAIT;
               end
            end
            ST_RSP: begin
               if (i_rsp_ready) begin
                  rsp_valid_q <= 1'b0;
                  cmd_ready_q <= 1'b1;
                  state_q     <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign o_cmd_ready = cmd_ready_q;
   assign o_wb_cyc    = cyc_q;
   assign o_wb_stb    = stb_q;
   assign o_wb_we     = we_q;
   assign o_wb_addr   = addr_q;
   assign o_wb_data   = wdata_q;
   assign o_rsp_valid = rsp_valid_q;
   assign o_rsp_data  = rsp_data_q;
   assign o_rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Self-checking bench for wb_cmd_master: directed cases plus randomized
// transfers against a slave model; inputs driven and outputs sampled on negedge.
module tb_wb_cmd_master;

   localparam int AW      = 8;
   localparam int DW      = 8;
   localparam int TIMEOUT = 15;

   logic          i_clk = 1'b0;
   logic          i_reset_n;
   logic          i_cmd_valid;
   logic          o_cmd_ready;
   logic          i_cmd_we;
   logic [AW-1:0] i_cmd_addr;
   logic [DW-1:0] i_cmd_data;
   logic          o_rsp_valid;
   logic          i_rsp_ready;
   logic [DW-1:0] o_rsp_data;
   logic          o_rsp_err;
   logic          o_wb_cyc;
   logic          o_wb_stb;
   logic          o_wb_we;
   logic [AW-1:0] o_wb_addr;
   logic [DW-1:0] o_wb_data;
   logic          i_wb_stall;
   logic          i_wb_ack;
   logic          i_wb_err;
   logic [DW-1:0] i_wb_data;

   int n_checks = 0;
   int n_errors = 0;

   always #5 i_clk = ~i_clk;

   wb_cmd_master #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .i_clk       (i_clk),
      .i_reset_n   (i_reset_n),
      .i_cmd_valid (i_cmd_valid),
      .o_cmd_ready (o_cmd_ready),
      .i_cmd_we    (i_cmd_we),
      .i_cmd_addr  (i_cmd_addr),
      .i_cmd_data  (i_cmd_data),
      .o_rsp_valid (o_rsp_valid),
      .i_rsp_ready (i_rsp_ready),
      .o_rsp_data  (o_rsp_data),
      .o_rsp_err   (o_rsp_err),
      .o_wb_cyc    (o_wb_cyc),
      .o_wb_stb    (o_wb_stb),
      .o_wb_we     (o_wb_we),
      .o_wb_addr   (o_wb_addr),
      .o_wb_data   (o_wb_data),
      .i_wb_stall  (i_wb_stall),
      .i_wb_ack    (i_wb_ack),
      .i_wb_err    (i_wb_err),
      .i_wb_data   (i_wb_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge i_clk);
   endtask

   // Reference rules: writes and errored transfers return zero data;
   // mode 0 = ACK, 1 = ERR, 2 = ERR and ACK together.
   function automatic logic [DW-1:0] model_data(input logic we, input int mode,
                                                input logic [DW-1:0] rdata);
      return (we || mode != 0) ? '0 : rdata;
   endfunction

   function automatic logic model_err(input int mode);
      return mode != 0;
   endfunction

   task automatic drive_cmd(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      i_cmd_valid = 1'b1;
      i_cmd_we    = we;
      i_cmd_addr  = addr;
      i_cmd_data  = data;
   endtask

   task automatic check_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      check("req_cyc", o_wb_cyc, 1);
      check("req_stb", o_wb_stb, 1);
      check("req_we", o_wb_we, we);
      check("req_adr", o_wb_addr, addr);
      if (we) check("req_dat", o_wb_data, data);
      check("req_cmd_ready", o_cmd_ready, 0);
   endtask

   task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data);
      check("idle_cmd_ready", o_cmd_ready, 1);
      drive_cmd(we, addr, data);
      tick();
      i_cmd_valid = 1'b0;
      check_req(we, addr, data);
   endtask

   task automatic slave_reply(input int mode, input logic [DW-1:0] rdata);
      i_wb_ack  = (mode != 1);
      i_wb_err  = (mode != 0);
      i_wb_data = rdata;
   endtask

   // Slave: stall_n stalled cycles, then accept; reply lat cycles after acceptance.
   task automatic bus(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                      input int stall_n, input int lat, input int mode, input logic [DW-1:0] rdata);
      i_wb_data = DW'($urandom);
      for (int i = 0; i < stall_n; i++) begin
         i_wb_stall = 1'b1;
         tick();
         check("stall_stb_held", o_wb_stb, 1);
         check("stall_adr_stable", o_wb_addr, addr);
         check("stall_we_stable", o_wb_we, we);
         check("stall_dat_stable", o_wb_data, data);
      end
      i_wb_stall = 1'b0;
      if (lat > 0) begin
         tick();
         check("wait_stb_low", o_wb_stb, 0);
         check("wait_cyc_high", o_wb_cyc, 1);
         for (int i = 1; i < lat; i++) begin
            tick();
            check("wait_cyc_high", o_wb_cyc, 1);
            check("wait_no_rsp", o_rsp_valid, 0);
         end
      end
      slave_reply(mode, rdata);
      tick();
      i_wb_ack = 1'b0;
      i_wb_err = 1'b0;
      check("end_cyc_low", o_wb_cyc, 0);
      check("end_stb_low", o_wb_stb, 0);
   endtask

   task automatic response(input logic [DW-1:0] exp_data, input logic exp_err, input int delay);
      check("rsp_valid", o_rsp_valid, 1);
      check("rsp_data", o_rsp_data, exp_data);
      check("rsp_err", o_rsp_err, exp_err);
      for (int i = 0; i < delay; i++) begin
         i_rsp_ready = 1'b0;
         tick();
         check("bp_rsp_valid", o_rsp_valid, 1);
         check("bp_rsp_data", o_rsp_data, exp_data);
         check("bp_rsp_err", o_rsp_err, exp_err);
         check("bp_cmd_ready", o_cmd_ready, 0);
         check("bp_cyc_low", o_wb_cyc, 0);
      end
      i_rsp_ready = 1'b1;
      tick();
      i_rsp_ready = 1'b0;
      check("hs_rsp_valid_low", o_rsp_valid, 0);
      check("hs_cmd_ready", o_cmd_ready, 1);
      check("hs_cyc_low", o_wb_cyc, 0);
   endtask

   initial begin
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic [DW-1:0] rdata;
      int            mode;
      int            n;

      i_reset_n   = 1'b0;
      i_cmd_valid = 1'b0;
      i_cmd_we    = 1'b0;
      i_cmd_addr  = '0;
      i_cmd_data  = '0;
      i_rsp_ready = 1'b0;
      i_wb_stall  = 1'b0;
      i_wb_ack    = 1'b0;
      i_wb_err    = 1'b0;
      i_wb_data   = '0;
      tick();
      tick();
      check("rst_cmd_ready", o_cmd_ready, 1);
      check("rst_cyc", o_wb_cyc, 0);
      check("rst_stb", o_wb_stb, 0);
      check("rst_we", o_wb_we, 0);
      check("rst_adr", o_wb_addr, 0);
      check("rst_dat", o_wb_data, 0);
      check("rst_rsp_valid", o_rsp_valid, 0);
      check("rst_rsp_data", o_rsp_data, 0);
      check("rst_rsp_err", o_rsp_err, 0);
      i_reset_n = 1'b1;
      tick();

      // Minimum-latency write: STB at cycle 1, ACK at 2, response at 3.
      issue(1'b1, 8'h12, 8'hA5);
      check("min_no_early_rsp", o_rsp_valid, 0);
      bus(1'b1, 8'h12, 8'hA5, 0, 1, 0, 8'hFF);
      response(model_data(1'b1, 0, 8'hFF), model_err(0), 0);

      // Read with three stall cycles, ACK two cycles after acceptance.
      issue(1'b0, 8'h34, 8'h00);
      bus(1'b0, 8'h34, 8'h00, 3, 2, 0, 8'h5C);
      response(8'h5C, 1'b0, 0);

      // ERR together with ACK: error wins, data forced to zero.
      issue(1'b0, 8'h21, 8'h00);
      bus(1'b0, 8'h21, 8'h00, 0, 1, 2, 8'h77);
      response(8'h00, 1'b1, 0);

      // Response backpressure with the next command already waiting.
      issue(1'b0, 8'h56, 8'h00);
      bus(1'b0, 8'h56, 8'h00, 0, 1, 0, 8'h3C);
      drive_cmd(1'b1, 8'h78, 8'h99);
      response(8'h3C, 1'b0, 5);
      tick();
      i_cmd_valid = 1'b0;
      check_req(1'b1, 8'h78, 8'h99);
      bus(1'b1, 8'h78, 8'h99, 1, 0, 0, 8'h11);
      response(8'h00, 1'b0, 0);

      // ACK while idle must not create a response.
      i_wb_ack = 1'b1;
      tick();
      tick();
      i_wb_ack = 1'b0;
      check("idle_ack_no_rsp", o_rsp_valid, 0);
      check("idle_ack_no_cyc", o_wb_cyc, 0);
      check("idle_ack_ready", o_cmd_ready, 1);

      for (int t = 0; t < 24; t++) begin
         we    = 1'($urandom_range(0, 1));
         addr  = AW'($urandom);
         data  = DW'($urandom);
         rdata = DW'($urandom);
         case ($urandom_range(0, 3))
            2:       mode = 1;
            3:       mode = 2;
            default: mode = 0;
         endcase
         issue(we, addr, data);
         bus(we, addr, data, $urandom_range(0, 3), $urandom_range(0, 3), mode, rdata);
         response(model_data(we, mode, rdata), model_err(mode), $urandom_range(0, 3));
      end

      // Slave that never answers.
      issue(1'b0, 8'h9A, 8'h00);
      i_wb_stall = 1'b0;
`ifdef WB_CMD_MASTER_TIMEOUT_EN
      n = 1;
      for (int i = 0; i < 200; i++) begin
         tick();
         if (!o_wb_cyc) break;
         n++;
      end
      check("tmo_cyc_cycles", n, TIMEOUT);
      response(8'h00, 1'b1, 0);
`else
      repeat (100) tick();
      check("no_tmo_cyc_high", o_wb_cyc, 1);
      check("no_tmo_no_rsp", o_rsp_valid, 0);
      i_reset_n = 1'b0;
      tick();
      i_reset_n = 1'b1;
      tick();
`endif

      // Reset while waiting for the reply; a late ACK afterwards is ignored.
      issue(1'b0, 8'hC3, 8'h00);
      i_wb_stall = 1'b0;
      tick();
      check("pre_rst_wait_cyc", o_wb_cyc, 1);
      i_reset_n = 1'b0;
      tick();
      i_reset_n = 1'b1;
      check("wrst_cyc", o_wb_cyc, 0);
      check("wrst_stb", o_wb_stb, 0);
      check("wrst_rsp_valid", o_rsp_valid, 0);
      check("wrst_cmd_ready", o_cmd_ready, 1);
      i_wb_ack  = 1'b1;
      i_wb_data = 8'hEE;
      tick();
      i_wb_ack = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("late_ack_no_rsp", o_rsp_valid, 0);
         check("late_ack_no_cyc", o_wb_cyc, 0);
         tick();
      end

      issue(1'b0, 8'h44, 8'h00);
      bus(1'b0, 8'h44, 8'h00, 0, 1, 0, 8'hB7);
      response(8'hB7, 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
